booth16_pp_gen: RTL

Sequential radix-16 Booth recoder and partial-product generator; the producer side of the partial-product path that feeds the shifting accumulator of the radix-16 multiplier. It latches a signed multiplicand/multiplier pair and precomputes the odd hard multiples. It then emits one signed partial product per accepted cycle, least-significant digit first, under a valid/ready handshake. The consumer shifts and accumulates each partial product by 4 bit positions per digit.

---
 rtl/booth16_pp_gen.sv | 110 +++++++++++
 1 files changed

// File: rtl/booth16_pp_gen.sv
// booth16_pp_gen: sequential radix-16 Booth recoder and partial-product
// generator. It latches a signed A/B pair, precomputes 3A/5A/7A, then emits
// one signed partial product per handshake, least-significant digit first.
module booth16_pp_gen #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] a_in,
    input  logic [N-1:0] b_in,
    output logic         busy,
    output logic         pp_valid,
    input  logic         pp_ready,
    output logic [N+3:0] pp_data,
    output logic [4:0]   pp_digit,
    output logic         pp_last
);

    localparam int D  = N / 4;
    localparam int IW = (D > 1) ? $clog2(D) : 1;
    localparam int W  = N + 4;

    typedef enum logic [1:0] {IDLE, PRECOMP, SCAN} state_t;

    state_t          state;
    logic [IW-1:0]   idx;
    logic [N-1:0]    a_reg;
    logic [N-1:0]    b_reg;
    logic [W-1:0]    m3;
    logic [W-1:0]    m5;
    logic [W-1:0]    m7;

    logic [W-1:0]    a_ext;
    logic [N:0]      b_ext;
    logic [4:0]      win;
    logic [4:0]      digit;
    logic [4:0]      neg_digit;
    logic [3:0]      mag;
    logic [W-1:0]    sel;
    logic [W-1:0]    prod;
    logic            at_last;

    // Control FSM, operand latch and hard-multiple precompute.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            idx   <= '0;
            a_reg <= '0;
            b_reg <= '0;
            m3    <= '0;
            m5    <= '0;
            m7    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_reg <= a_in;
                        b_reg <= b_in;
                        state <= PRECOMP;
                    end
                end
                PRECOMP: begin
                    m3    <= a_ext + (a_ext << 1);
                    m5    <= a_ext + (a_ext << 2);
                    m7    <= (a_ext << 3) - a_ext;
                    idx   <= '0;
                    state <= SCAN;
                end
                SCAN: begin
                    if (pp_ready) begin
                        if (at_last) state <= IDLE;
                        else         idx   <= idx + IW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Booth recoding of the current digit and signed multiple selection.
    always_comb begin
        a_ext     = {{4{a_reg[N-1]}}, a_reg};
        b_ext     = {b_reg, 1'b0};
        win       = b_ext[{idx, 2'b00} +: 5];
        // window value = signed top nibble plus the borrowed lower bit
        digit     = {win[4], win[4:1]} + {4'b0000, win[0]};
        neg_digit = '0 - digit;
        mag       = digit[4] ? neg_digit[3:0] : digit[3:0];
        at_last   = (idx == IW'(D - 1));
        case (mag)
            4'd1:    sel = a_ext;
            4'd2:    sel = a_ext << 1;
            4'd3:    sel = m3;
            4'd4:    sel = a_ext << 2;
            4'd5:    sel = m5;
            4'd6:    sel = m3 << 1;
            4'd7:    sel = m7;
            4'd8:    sel = a_ext << 3;
            default: sel = '0;
        endcase
        prod      = digit[4] ? ('0 - sel) : sel;
        busy      = (state != IDLE);
        pp_valid  = (state == SCAN);
        pp_data   = pp_valid ? prod : '0;
        pp_digit  = pp_valid ? digit : '0;
        pp_last   = pp_valid & at_last;
    end

endmodule
